// File: rtl/mem_port_arbiter.sv
// Shares one synchronous BRAM port between instruction fetch and load/store.
// Round-robin arbitration, one access in flight, all outputs registered.
module mem_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic r_gnt_d;
    logic r_last_d;
    logic r_wr;

    logic w_gnt_d_nx;
    logic w_last_d_nx;
    logic w_wr_nx;
    logic w_pick_d;
    logic w_we_nx;
    logic w_iready_nx;
    logic w_dready_nx;

    logic [ADDR_W-1:0] w_addr_nx;
    logic [DATA_W-1:0] w_din_nx;
    logic [DATA_W-1:0] w_idata_nx;
    logic [DATA_W-1:0] w_drdata_nx;

    // Data wins when it is alone, or on contention when fetch went last.
    assign w_pick_d = d_req & (~i_req | ~r_last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_gnt_d_nx  = r_gnt_d;
        w_last_d_nx = r_last_d;
        w_wr_nx     = r_wr;
        w_we_nx     = 1'b0;
        w_addr_nx   = mem_addr;
        w_din_nx    = mem_din;
        w_iready_nx = 1'b0;
        w_dready_nx = 1'b0;
        w_idata_nx  = i_data;
        w_drdata_nx = d_rdata;
        unique case (r_state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    w_state_nx  = S_ISSUE;
                    w_gnt_d_nx  = w_pick_d;
                    w_last_d_nx = w_pick_d;
                    if (w_pick_d) begin
                        w_wr_nx   = d_we;
                        w_we_nx   = d_we;
                        w_addr_nx = d_addr;
                        w_din_nx  = d_wdata;
                    end else begin
                        w_wr_nx   = 1'b0;
                        w_addr_nx = i_addr;
                    end
                end
            end
            S_ISSUE: begin
                w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                w_state_nx = S_RESP;
                if (r_gnt_d) begin
                    w_dready_nx = 1'b1;
                    if (!r_wr) begin
                        w_drdata_nx = mem_dout;
                    end
                end else begin
                    w_iready_nx = 1'b1;
                    w_idata_nx  = mem_dout;
                end
            end
            S_RESP: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_d  <= 1'b0;
            r_last_d <= 1'b1;
            r_wr     <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            i_ready  <= 1'b0;
            d_ready  <= 1'b0;
            i_data   <= '0;
            d_rdata  <= '0;
        end else begin
            r_gnt_d  <= w_gnt_d_nx;
            r_last_d <= w_last_d_nx;
            r_wr     <= w_wr_nx;
            mem_we   <= w_we_nx;
            mem_addr <= w_addr_nx;
            mem_din  <= w_din_nx;
            i_ready  <= w_iready_nx;
            d_ready  <= w_dready_nx;
            i_data   <= w_idata_nx;
            d_rdata  <= w_drdata_nx;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural BRAM.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [11:0] i_addr;
    logic        i_ready;
    logic [31:0] i_data;
    logic        d_req;
    logic        d_we;
    logic [11:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    logic [31:0] m_drdata;

    logic [31:0] ram [4096];
    bit ram_init;

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!ram_init) begin
            ram[3]   <= 32'hAAAA5555;
            ram[5]   <= 32'hDEADBEEF;
            ram_init <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_din;
        end
        mem_dout <= ram[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) we_cnt++;
            if (i_ready && d_ready) begin
                chk("both_ready", 32'd1, 32'd0);
            end else if (i_ready || d_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_ready", {31'd0, d_ready}, 32'hFFFFFFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("grantee", {31'd0, d_ready}, {31'd0, e.is_d});
                    chk("ready_cycle", cyc, e.cyc);
                    chk("resp_data", d_ready ? d_rdata : i_data, e.data);
                end
            end
        end
    end

    task automatic wait_ready(input bit is_d);
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_d ? d_ready : i_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic access(input bit is_d, input bit we,
                          input logic [11:0] a, input logic [31:0] wd,
                          input logic [31:0] ed);
        int w0;
        @(posedge clk); #1;
        w0 = we_cnt;
        if (is_d) begin
            d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
        end else begin
            i_req = 1; i_addr = a;
        end
        q.push_back('{is_d, ed, cyc + 3});
        @(negedge clk);
        @(negedge clk);
        chk("issue_addr", {20'd0, mem_addr}, {20'd0, a});
        chk("issue_we", {31'd0, mem_we}, {31'd0, we});
        wait_ready(is_d);
        @(posedge clk); #1;
        i_req = 0;
        d_req = 0;
        chk("we_pulses", we_cnt - w0, we ? 1 : 0);
    endtask

    initial begin
        int w0;
        int k;
        rst_n = 0; i_req = 0; i_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_drdata = 0;
        #3;
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", {20'd0, mem_addr}, 32'd0);
        chk("rst_din", mem_din, 32'd0);
        chk("rst_rdy", {30'd0, i_ready, d_ready}, 32'd0);
        chk("rst_idata", i_data, 32'd0);
        chk("rst_drdata", d_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        access(0, 0, 12'd5, 32'd0, 32'hDEADBEEF);

        w0 = we_cnt;
        repeat (8) @(negedge clk);
        chk("idle_no_we", we_cnt - w0, 32'd0);
        chk("idle_we_low", {31'd0, mem_we}, 32'd0);

        access(1, 0, 12'd3, 32'd0, 32'hAAAA5555);
        access(1, 1, 12'h7FF, 32'h12345678, 32'hAAAA5555);
        access(1, 0, 12'h7FF, 32'd0, 32'h12345678);

        @(posedge clk); #1;
        d_req = 1; d_we = 1; d_addr = 12'd3; d_wdata = 32'h11111111;
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_before", {31'd0, mem_we}, 32'd1);
        rst_n = 0;
        #1;
        chk("abort_we_after", {31'd0, mem_we}, 32'd0);
        d_req = 0; d_we = 0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_ready", {31'd0, d_ready}, 32'd0);
        end
        @(posedge clk); #1 rst_n = 1;
        access(1, 0, 12'd3, 32'd0, 32'hAAAA5555);

        @(posedge clk); #1;
        i_req = 1; i_addr = 12'd5;
        repeat (3) @(posedge clk);
        #2;
        chk("resp_ready", {31'd0, i_ready}, 32'd1);
        rst_n = 0;
        #1;
        i_req = 0;
        chk("rresp_rdy", {30'd0, i_ready, d_ready}, 32'd0);
        chk("rresp_idata", i_data, 32'd0);
        chk("rresp_drdata", d_rdata, 32'd0);
        chk("rresp_addr", {20'd0, mem_addr}, 32'd0);
        chk("rresp_din", mem_din, 32'd0);
        chk("rresp_we", {31'd0, mem_we}, 32'd0);

        i_req = 1; i_addr = 12'd5;
        d_req = 1; d_we = 0; d_addr = 12'h7FF;
        @(posedge clk); #1 rst_n = 1;
        k = cyc;
        q.push_back('{0, 32'hDEADBEEF, k + 3});
        q.push_back('{1, 32'h12345678, k + 7});
        q.push_back('{0, 32'hDEADBEEF, k + 11});
        q.push_back('{1, 32'h12345678, k + 15});
        for (int j = 0; j < 4; j++) wait_ready(j % 2 == 1);
        @(posedge clk); #1;
        i_req = 0;
        d_req = 0;
        repeat (6) @(negedge clk);

        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
